// File: rtl/attosoc_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave port.
// One transaction in flight; slave stalls are bounded by a TIMEOUT watchdog.
module attosoc_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;

  logic        grant_m1;
  logic        owner_valid;
  logic        done;
  logic        timed_out;
  logic [31:0] resp_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wait_cnt_q   <= 8'd0;
      s_addr_q     <= 32'd0;
      s_wdata_q    <= 32'd0;
      s_wstrb_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    grant_m1     = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    resp_data    = 32'd0;
    owner_valid  = owner_q ? m1_valid : m0_valid;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // On contention the master that was not served last wins.
          grant_m1   = m1_valid && (!m0_valid || !last_owner_q);
          state_d    = BUSY;
          owner_d    = grant_m1;
          wait_cnt_d = 8'd0;
          s_addr_d   = grant_m1 ? m1_addr  : m0_addr;
          s_wdata_d  = grant_m1 ? m1_wdata : m0_wdata;
          s_wstrb_d  = grant_m1 ? m1_wstrb : m0_wstrb;
        end
      end
      BUSY: begin
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          done         = 1'b1;
          resp_data    = s_rdata;
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          done         = 1'b1;
          timed_out    = 1'b1;
          resp_data    = 32'hFFFF_FFFF;
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_ready    = done && !owner_q;
  assign m1_ready    = done && owner_q;
  assign m0_rdata    = m0_ready ? resp_data : 32'd0;
  assign m1_rdata    = m1_ready ? resp_data : 32'd0;
  assign s_valid     = (state_q == BUSY);
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign owner       = owner_q;
  assign timeout_err = timed_out;

endmodule

// File: tb/tb_attosoc_mem_arbiter.sv
// Bench for attosoc_mem_arbiter: vector table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_attosoc_mem_arbiter;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready, owner, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  int checks = 0;
  int errors = 0;

  attosoc_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0v;
    logic [31:0] m0a;
    logic        m1v;
    logic [31:0] m1a;
    logic        srdy;
    logic [31:0] srd;
    logic        sv;
    logic [31:0] saddr;
    logic        r0;
    logic        r1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        own;
    logic        terr;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic sv, input logic own,
                            input logic r0, input logic r1,
                            input logic [31:0] rd0, input logic [31:0] rd1, input logic terr);
    chk({tag, ".s_valid"}, 32'(s_valid), 32'(sv));
    chk({tag, ".owner"}, 32'(owner), 32'(own));
    chk({tag, ".m0_ready"}, 32'(m0_ready), 32'(r0));
    chk({tag, ".m1_ready"}, 32'(m1_ready), 32'(r1));
    chk({tag, ".m0_rdata"}, m0_rdata, rd0);
    chk({tag, ".m1_rdata"}, m1_rdata, rd1);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(terr));
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    s_ready  = 1'b0; s_rdata = 32'd0;
  endtask

  // Asserts reset, checks the forced values, releases it mid-cycle.
  task automatic do_reset(input string tag);
    idle_inputs();
    resetn = 1'b0;
    #1;
    expect_cyc({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk({tag, ".rst.s_addr"}, s_addr, 32'd0);
    chk({tag, ".rst.s_wdata"}, s_wdata, 32'd0);
    chk({tag, ".rst.s_wstrb"}, 32'(s_wstrb), 32'd0);
    next();
    next();
    resetn = 1'b1;
    m0_valid = 1'b1;
    #2;
    chk({tag, ".release.s_valid"}, 32'(s_valid), 32'd0);
    m0_valid = 1'b0;
  endtask

  // m1 write against a silent slave; optionally the slave answers at the limit.
  task automatic run_timeout(input bit ready_at_limit, input string tag);
    do_reset(tag);
    next();
    m1_valid = 1'b1; m1_addr = 32'h0200_0000; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
    #3;
    expect_cyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= TO + 1; k++) begin
      next();
      if (ready_at_limit && k == TO + 1) begin
        s_ready = 1'b1; s_rdata = 32'hBEEF_0001;
      end
      #3;
      if (k <= TO)
        expect_cyc($sformatf("%s.wait%0d", tag, k), 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      else if (ready_at_limit)
        expect_cyc({tag, ".limit"}, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'hBEEF_0001, 1'b0);
      else
        expect_cyc({tag, ".limit"}, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1);
      if (k == 1 || k == 8) begin
        chk({tag, ".s_addr"}, s_addr, 32'h0200_0000);
        chk({tag, ".s_wdata"}, s_wdata, 32'h0000_00A5);
        chk({tag, ".s_wstrb"}, 32'(s_wstrb), 32'd1);
      end
      if (k == 4) begin
        m1_addr = 32'hDEAD_0000; m1_wdata = 32'h1111_1111; m1_wstrb = 4'hF;
        m0_addr = 32'h3333_3333;
      end
    end
    next();
    m1_valid = 1'b0; s_ready = 1'b0;
    #3;
    expect_cyc({tag, ".after"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Reference model state: one outstanding transaction at most.
  bit          mbusy;
  int          mown, mlast, mage;
  logic [31:0] ea, ew;
  logic [3:0]  es;

  initial begin
    logic        v[2];
    logic [31:0] a[2], w[2];
    logic [3:0]  st[2];
    logic        e_r[2], prev_r[2];
    logic [31:0] e_rd[2];
    logic        e_te, done, abort;
    int          mode;

    idle_inputs();

    // {m0v,m0a, m1v,m1a, srdy,srd, sv,saddr, r0,r1, rd0,rd1, own,terr}
    vt[0]  = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b1, 32'h1234_5678, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b1, 32'h1234_5678, 1'b1, 32'h10, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 32'h0000_CAFE, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 32'h0000_CAFE, 1'b1, 32'h20, 1'b0, 1'b1, 32'h0, 32'h0000_CAFE, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'h55,        1'b1, 32'h30, 1'b1, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'h66,        1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 32'h66, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'h77,        1'b1, 32'h30, 1'b1, 1'b0, 32'h77, 32'h0, 1'b0, 1'b0};

    // Basic read, IDLE-time s_ready ignored, round-robin alternation.
    do_reset("tbl");
    for (int i = 0; i < 11; i++) begin
      next();
      m0_valid = vt[i].m0v; m0_addr = vt[i].m0a;
      m1_valid = vt[i].m1v; m1_addr = vt[i].m1a;
      s_ready  = vt[i].srdy; s_rdata = vt[i].srd;
      #3;
      expect_cyc($sformatf("tbl%0d", i), vt[i].sv, vt[i].own, vt[i].r0, vt[i].r1,
                 vt[i].rd0, vt[i].rd1, vt[i].terr);
      if (vt[i].sv)
        chk($sformatf("tbl%0d.s_addr", i), s_addr, vt[i].saddr);
    end

    run_timeout(1'b0, "tmo");
    run_timeout(1'b1, "tmo_rdy");

    // Reset in the middle of an m1 transaction.
    do_reset("rstbusy");
    next();
    m1_valid = 1'b1; m1_addr = 32'h44;
    #3;
    next();
    #3;
    expect_cyc("rstbusy.busy", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next();
    resetn = 1'b0;
    #1;
    expect_cyc("rstbusy.inrst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    s_ready = 1'b1;
    #1;
    chk("rstbusy.inrst.m1_ready", 32'(m1_ready), 32'd0);
    next();
    m0_valid = 1'b1; m0_addr = 32'h88; s_ready = 1'b0;
    resetn = 1'b1;
    #3;
    expect_cyc("rstbusy.rel", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next();
    #3;
    expect_cyc("rstbusy.grant", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("rstbusy.s_addr", s_addr, 32'h88);

    // Owner abort in BUSY cycle 3, then the waiting m1 is served.
    do_reset("abort");
    next();
    m0_valid = 1'b1; m0_addr = 32'h100; m1_valid = 1'b1; m1_addr = 32'h200;
    #3;
    for (int k = 1; k <= 3; k++) begin
      next();
      if (k == 3) m0_valid = 1'b0;
      #3;
      expect_cyc($sformatf("abort.busy%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk($sformatf("abort.busy%0d.s_addr", k), s_addr, 32'h100);
      if (k == 1) m0_addr = 32'h999;
    end
    next();
    #3;
    expect_cyc("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next();
    #3;
    expect_cyc("abort.m1", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("abort.m1.s_addr", s_addr, 32'h200);

    // Randomized traffic against the reference model.
    do_reset("rnd");
    mbusy = 1'b0; mown = 0; mlast = 1; mage = 0;
    ea = 32'd0; ew = 32'd0; es = 4'd0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = 32'd0; w[i] = 32'd0; st[i] = 4'd0; prev_r[i] = 1'b0;
    end
    mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next();
      if (cyc % 50 == 0) mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 2; i++) begin
        if (v[i] && prev_r[i]) begin
          v[i] = 1'b0;
        end else if (!v[i]) begin
          if ($urandom_range(0, 9) < 3) begin
            v[i] = 1'b1; a[i] = $urandom; w[i] = $urandom; st[i] = 4'($urandom_range(0, 15));
          end
        end else if (mbusy && mown == i && $urandom_range(0, 99) < 3) begin
          v[i] = 1'b0;
        end
      end
      m0_valid = v[0]; m0_addr = a[0]; m0_wdata = w[0]; m0_wstrb = st[0];
      m1_valid = v[1]; m1_addr = a[1]; m1_wdata = w[1]; m1_wstrb = st[1];
      case (mode)
        0:       s_ready = ($urandom_range(0, 9) < 8);
        1:       s_ready = ($urandom_range(0, 9) < 2);
        default: s_ready = 1'b0;
      endcase
      s_rdata = $urandom;
      #3;

      e_r[0] = 1'b0; e_r[1] = 1'b0; e_rd[0] = 32'd0; e_rd[1] = 32'd0;
      e_te = 1'b0; done = 1'b0; abort = 1'b0;
      if (mbusy) begin
        if (!v[mown]) abort = 1'b1;
        else if (s_ready) begin
          done = 1'b1; e_rd[mown] = s_rdata;
        end else if (mage == TO) begin
          done = 1'b1; e_te = 1'b1; e_rd[mown] = 32'hFFFF_FFFF;
        end
        if (done) e_r[mown] = 1'b1;
      end
      expect_cyc($sformatf("rnd%0d", cyc), mbusy, 1'(mown), e_r[0], e_r[1], e_rd[0], e_rd[1], e_te);
      if (mbusy) begin
        chk($sformatf("rnd%0d.s_addr", cyc), s_addr, ea);
        chk($sformatf("rnd%0d.s_wdata", cyc), s_wdata, ew);
        chk($sformatf("rnd%0d.s_wstrb", cyc), 32'(s_wstrb), 32'(es));
      end

      if (mbusy) begin
        if (done) begin
          mlast = mown; mbusy = 1'b0;
        end else if (abort) begin
          mbusy = 1'b0;
        end else begin
          mage++;
        end
      end else if (v[0] || v[1]) begin
        mown  = (v[0] && v[1]) ? 1 - mlast : (v[1] ? 1 : 0);
        mbusy = 1'b1; mage = 0;
        ea = a[mown]; ew = w[mown]; es = st[mown];
      end
      prev_r[0] = e_r[0]; prev_r[1] = e_r[1];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
